// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the execute-stage units.
// ALU and multiply/divide operation encodings.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR
  } alu_t;

  typedef enum logic [2:0] {
    MUL,
    MULH,
    MULHSU,
    MULHU,
    DIV,
    DIVU,
    REM,
    REMU
  } muldiv_t;

endpackage

// File: rtl/muldiv_seq_alu.sv
// Small 32-bit ALU, reused here for two's-complement negation.
// Purely combinational.
module muldiv_seq_alu
  import muldiv_seq_pkg::*;
(
  input  alu_t        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // operation select
  always_comb begin
    y = '0;
    unique case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// Fixed 35-cycle latency; optional divide-by-zero early exit.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  muldiv_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {
    IDLE, PREP, ITER, FIX, DONE
  } state_t;

  state_t      st, nx;
  muldiv_t     op_q;
  logic [31:0] a_q, b_q, mc_q, res_q;
  logic [63:0] acc, step;
  logic [4:0]  cnt;
  logic        sgn_q;

  logic        is_div, is_mulh, hi_sel;
  logic        neg_a, neg_b, b_zero, bypass;
  logic [31:0] alu_in, alu_y, raw, fix_val;
  logic [31:0] abs_a, abs_b;
  logic [32:0] sub_a, sub_b, diff, sum33, hi_n;

  assign is_div  = op_q[2];
  assign is_mulh = op_q inside {MULH, MULHSU, MULHU};
  assign hi_sel  = is_mulh || (op_q inside {REM, REMU});
  assign neg_a   = a_q[31] &&
                   !(op_q inside {MULHU, DIVU, REMU});
  assign neg_b   = b_q[31] &&
                   (op_q inside {MUL, MULH, DIV, REM});
  assign b_zero  = (b_q == 32'd0);
  assign bypass  = EARLY_OUT && is_div && b_zero;

  // Word to sign-fix: product half, quotient or remainder.
  assign raw = hi_sel ? acc[63:32] : acc[31:0];

  // PREP negates a; FIX negates the selected word.
  assign alu_in = (st == PREP) ? a_q : raw;

  muldiv_seq_alu u_alu (
    .op (ALU_SUB),
    .a  (32'd0),
    .b  (alu_in),
    .y  (alu_y)
  );

  // The idle divide subtractor negates b during PREP.
  always_comb begin
    sub_a = {acc[63:32], acc[31]};
    sub_b = {1'b0, mc_q};
    if (st == PREP) begin
      sub_a = 33'd0;
      sub_b = {1'b0, b_q};
    end
  end

  assign diff  = sub_a - sub_b;
  assign abs_a = neg_a ? alu_y : a_q;
  assign abs_b = neg_b ? diff[31:0] : b_q;
  assign sum33 = {1'b0, acc[63:32]} + {1'b0, mc_q};
  assign hi_n  = acc[0] ? sum33 : {1'b0, acc[63:32]};

  // One shift-add or one restoring-divide step.
  always_comb begin
    step = {hi_n, acc[31:1]};
    if (is_div) begin
      if (!diff[32])
        step = {diff[31:0], acc[30:0], 1'b1};
      else
        step = {acc[62:0], 1'b0};
    end
  end

  // Negating a 64-bit product: the borrow out of the
  // low word is set unless it is zero, so the high word
  // is either negated or merely inverted.
  always_comb begin
    fix_val = raw;
    if (sgn_q) begin
      if (is_mulh && (acc[31:0] != 32'd0))
        fix_val = ~raw;
      else
        fix_val = alu_y;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nx;
  end

  // next-state logic
  always_comb begin
    nx = st;
    if (flush) begin
      nx = IDLE;
    end else begin
      unique case (st)
        IDLE: if (start) nx = PREP;
        PREP: nx = bypass ? FIX : ITER;
        ITER: if (cnt == 5'd31) nx = FIX;
        FIX:  nx = DONE;
        DONE: nx = IDLE;
        default: nx = IDLE;
      endcase
    end
  end

  // operand capture, iteration datapath and result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= MUL;
      a_q   <= '0;
      b_q   <= '0;
      mc_q  <= '0;
      acc   <= '0;
      cnt   <= '0;
      sgn_q <= 1'b0;
      res_q <= '0;
    end else if (!flush) begin
      case (st)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
          end
        end
        PREP: begin
          mc_q <= abs_b;
          cnt  <= '0;
          if (bypass)
            acc <= {abs_a, 32'hFFFF_FFFF};
          else
            acc <= {32'd0, abs_a};
          if (!is_div)
            sgn_q <= neg_a ^ neg_b;
          else if (op_q[1])
            sgn_q <= neg_a;
          else
            sgn_q <= (neg_a ^ neg_b) && !b_zero;
        end
        ITER: begin
          acc <= step;
          cnt <= cnt + 5'd1;
        end
        FIX: res_q <= fix_val;
        default: ;
      endcase
    end
  end

  assign ready  = (st == IDLE);
  assign busy   = (st == PREP) || (st == ITER) || (st == FIX);
  assign done   = (st == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq.
// Hand-computed expectations, one checking task.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk, rst, start, flush;
  muldiv_t     op;
  logic [31:0] a, b, result;
  logic        ready, busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, count cycles to done, check result.
  task automatic run_op(input string tag, input muldiv_t o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat);
    int cyc;
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    cyc = 1;
    while (cyc < 60 && !done) begin
      start = (cyc == 5);
      op = MULHU;
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_lat"}, cyc, lat);
    check(tag, result, exp);
    tick();
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_rdy"}, {31'd0, ready}, 32'd1);
  endtask

  // Idle for n cycles, report whether done ever rose.
  task automatic idle_watch(input int n, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    logic seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    op = MUL; a = '0; b = '0;
    tick();
    tick();
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    run_op("mul_neg",   MUL,    32'd7,        32'hFFFF_FFFD,
           32'hFFFF_FFEB, 35);
    run_op("mulhu_max", MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 35);
    run_op("mulh_m1",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'h0000_0000, 35);
    run_op("mulhsu",    MULHSU, 32'hFFFF_FFFF, 32'd2,
           32'hFFFF_FFFF, 35);
    run_op("mulh_borrow", MULH, 32'hFFFF_0000, 32'h0001_0000,
           32'hFFFF_FFFF, 35);
    run_op("div_ovf",   DIV,    32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 35);
    run_op("rem_ovf",   REM,    32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 35);
    run_op("divu_z",    DIVU,   32'd100,      32'd0,
           32'hFFFF_FFFF, 3);
    run_op("remu_z",    REMU,   32'd100,      32'd0,
           32'd100, 3);
    run_op("div_neg",   DIV,    32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFD, 35);
    run_op("rem_neg",   REM,    32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 35);
    run_op("divu",      DIVU,   32'd100,      32'd7,
           32'd14, 35);
    run_op("remu",      REMU,   32'd100,      32'd7,
           32'd2, 35);
    run_op("rem_z_neg", REM,    32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFF9, 3);
    run_op("div_negb",  DIV,    32'd7,        32'hFFFF_FFFE,
           32'hFFFF_FFFD, 35);

    // flush at ITER cycle 10
    op = DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 11; i++) tick();
    check("fl_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_ready", {31'd0, ready}, 32'd1);
    check("fl_busy", {31'd0, busy}, 32'd0);
    idle_watch(40, seen);
    check("fl_no_done", {31'd0, seen}, 32'd0);
    check("fl_result", result, 32'hFFFF_FFFD);

    // flush beats a simultaneous start
    op = MUL; a = 32'd3; b = 32'd5;
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("fl_win_ready", {31'd0, ready}, 32'd1);
    idle_watch(40, seen);
    check("fl_win_no_done", {31'd0, seen}, 32'd0);
    check("fl_win_result", result, 32'hFFFF_FFFD);

    // async reset at ITER cycle 20
    op = MUL; a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 21; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("rs_async_ready", {31'd0, ready}, 32'd1);
    check("rs_async_result", result, 32'd0);
    rst = 1'b0;
    tick();
    check("rs_ready", {31'd0, ready}, 32'd1);
    idle_watch(40, seen);
    check("rs_no_done", {31'd0, seen}, 32'd0);
    check("rs_result", result, 32'd0);

    run_op("mul_after", MUL, 32'd6, 32'd7, 32'd42, 35);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
